led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
- Parametrised LED pattern generator driving an N-bit LED bank on the board.
- Replaces fixed-width running-LED logic with a width parameter, a programmable tick prescaler and four run-time-selectable patterns.
- Adds enable/pause, restart on mode change, and a once-per-pattern cycle_done pulse.
- Sits between the board clock and the LED pins; the control inputs come from switches or a host register.

Parameters:
- N, 26, number of LEDs; legal range N >= 2.
- DIV, 50000000, clock cycles per pattern step; legal range DIV >= 1.
- Derived widths (not parameters): PW = clog2(N) for pos; CW = max(1, clog2(DIV)) for the prescaler.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous reset, active-low.
- en  in  1  1 = prescaler and pattern advance; 0 = freeze all state.
- mode  in  2  pattern select: 0 SCAN, 1 BOUNCE, 2 FILL, 3 TRAIL.
- leds  out  N  registered LED drive; bit 0 is the first LED.
- pos  out  PW  registered current step position.
- cycle_done  out  1  registered one-cycle pulse at the end of each full pattern.

Behaviour:
- Reset (rst_n=0 at a clk edge) sets:
  - prescaler = 0, pos = 0, dir = up, phase = FWD, empty = 0;
  - leds = 1 (only bit 0 set), cycle_done = 0;
  - mode_q = mode (the value on mode that cycle).
- Reset overrides every other input.
- Prescaler:
  - When en=1, counts 0..DIV-1 and wraps.
  - tick is internal and is asserted when en=1 and prescaler==DIV-1.
  - With DIV=1, tick fires on every enabled cycle.
  - When en=0: prescaler, pos, leds and phase all hold, and cycle_done=0.
- Mode change:
  - mode_q holds the registered mode.
  - If mode != mode_q, restart the same cycle: mode_q <= mode, prescaler = 0, pos = 0, dir = up, phase = FWD, empty = 0, leds = 1, cycle_done = 0.
  - Restart happens regardless of en and takes priority over tick.
- Step update:
  - State and leds update on the clk edge at which tick is true, so leds change 1 cycle after the tick condition.
  - Otherwise leds is stable.
  - cycle_done is 1 only in the cycle that follows a pattern-completing tick. It is coincident with the leds value that starts the new pattern and is 0 at all other times.
- SCAN (mode 0):
  - leds = one-hot(pos).
  - pos advances 0,1,..,N-1,0.
  - The N-1 -> 0 wrap asserts cycle_done.
  - Period N ticks.
- BOUNCE (mode 1):
  - leds = one-hot(pos).
  - pos goes 0..N-1 with dir up.
  - At N-1, dir flips and pos steps to N-2; pos then goes down to 0.
  - At 0, dir flips and pos steps to 1.
  - Each endpoint is shown for one tick.
  - The 1 -> 0 step (dir down) asserts cycle_done.
  - Period 2N-2 ticks; for N=2 this is an alternation between the two LEDs.
- FILL (mode 2):
  - leds = thermometer, bits [pos:0] set.
  - pos advances 0..N-1 (all ones).
  - The next tick enters the empty state: leds = 0, pos = 0, cycle_done asserted.
  - The tick after that shows leds = 1.
  - Period N+1 ticks.
- TRAIL (mode 3):
  - Phase FWD: leds = one-hot(pos), pos 0..N-1.
  - At pos N-1, the next tick enters phase BACK with pos = N-2 and leds bits [N-1:pos] set; pos then decrements.
  - At pos 0 in BACK (all ones), the next tick returns to FWD with pos = 0 and leds = 1, and asserts cycle_done.
  - Period 2N-1 ticks.
- Internal state: phase, dir and the empty flag are internal. The inactive fields are ignored in each mode and are cleared on restart.
- Arithmetic: pos never exceeds N-1 and never underflows. Boundary detection uses equality against 0 and N-1, not wrap-around.

Test Plan:
- Reset/hold, N=4, DIV=3: rst_n=0 with en=1 -> leds=0001, pos=0, cycle_done=0. Release with en=0 for 10 cycles -> leds stays 0001.
- SCAN, en=1, mode=0 -> leds changes every 3 cycles: 0001,0010,0100,1000,0001. cycle_done=1 for exactly the one cycle leds returns to 0001.
- BOUNCE, mode=1 -> 0001,0010,0100,1000,0100,0010,0001 (cycle_done), 0010. Period 6 ticks = 18 cycles.
- FILL, mode=2 -> 0001,0011,0111,1111,0000 (cycle_done), 0001. TRAIL, mode=3 -> 0001,0010,0100,1000,1100,1110,1111,0001 (cycle_done).
- Mode change mid-pattern: at SCAN leds=0100, switch mode to 2 with en=0 -> next cycle leds=0001, pos=0, prescaler=0, cycle_done=0. Set en=1 -> first step 3 cycles later.
- Reset mid-pattern: TRAIL in BACK phase (leds=1110), pulse rst_n=0 for 1 cycle -> leds=0001, phase FWD. Also, N=2, DIV=1, mode=1 -> leds alternates 01,10 every cycle with cycle_done on each return to 01.

Source files
------------

// File: rtl/led_pattern_gen.sv
// LED pattern generator: N-bit LED bank stepped by a programmable prescaler.
// Four run-time patterns (SCAN, BOUNCE, FILL, TRAIL), with pause, restart
// on mode change and a one-cycle pulse when each full pattern completes.
module led_pattern_gen #(
    parameter int unsigned N   = 26,
    parameter int unsigned DIV = 50000000,
    localparam int unsigned PW = $clog2(N),
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [1:0]    mode,
    output logic [N-1:0]  leds,
    output logic [PW-1:0] pos,
    output logic          cycle_done
);

    typedef enum logic [1:0] {
        M_SCAN   = 2'd0,
        M_BOUNCE = 2'd1,
        M_FILL   = 2'd2,
        M_TRAIL  = 2'd3
    } mode_e;

    typedef enum logic {
        PH_FWD  = 1'b0,
        PH_BACK = 1'b1
    } phase_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam logic [CW-1:0] PRESC_LAST = CW'(DIV - 1);
    localparam logic [PW-1:0] POS_LAST   = PW'(N - 1);
    localparam logic [PW-1:0] POS_PENULT = PW'(N - 2);

    logic [CW-1:0] presc_q, presc_d;
    logic [PW-1:0] pos_q, pos_d;
    logic          dir_q, dir_d;
    phase_e        phase_q, phase_d;
    logic          empty_q, empty_d;
    logic [N-1:0]  leds_q, leds_d;
    logic          cycle_done_q, cycle_done_d;
    mode_e         mode_q, mode_d;
    logic          tick_c;

    // Single LED at position p
    function automatic logic [N-1:0] onehot(input logic [PW-1:0] p);
        return N'(1) << p;
    endfunction

    // Bits [p:0] set
    function automatic logic [N-1:0] therm(input logic [PW-1:0] p);
        logic [N-1:0] oh;
        oh = onehot(p);
        return (oh << 1) - N'(1);
    endfunction

    // Bits [N-1:p] set
    function automatic logic [N-1:0] upper(input logic [PW-1:0] p);
        return ~(onehot(p) - N'(1));
    endfunction

    // State register; reset also captures the current mode so no restart follows
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q      <= '0;
            pos_q        <= '0;
            dir_q        <= DIR_UP;
            phase_q      <= PH_FWD;
            empty_q      <= 1'b0;
            leds_q       <= N'(1);
            cycle_done_q <= 1'b0;
            mode_q       <= mode_e'(mode);
        end else begin
            presc_q      <= presc_d;
            pos_q        <= pos_d;
            dir_q        <= dir_d;
            phase_q      <= phase_d;
            empty_q      <= empty_d;
            leds_q       <= leds_d;
            cycle_done_q <= cycle_done_d;
            mode_q       <= mode_d;
        end
    end

    // Prescaler, restart and per-pattern step logic
    always_comb begin
        presc_d      = presc_q;
        pos_d        = pos_q;
        dir_d        = dir_q;
        phase_d      = phase_q;
        empty_d      = empty_q;
        leds_d       = leds_q;
        cycle_done_d = 1'b0;
        mode_d       = mode_q;
        tick_c       = en && (presc_q == PRESC_LAST);

        if (mode != mode_q) begin
            // Restart wins over both pause and tick
            mode_d  = mode_e'(mode);
            presc_d = '0;
            pos_d   = '0;
            dir_d   = DIR_UP;
            phase_d = PH_FWD;
            empty_d = 1'b0;
            leds_d  = N'(1);
        end else if (en) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + CW'(1);
            if (tick_c) begin
                case (mode_q)
                    M_SCAN: begin
                        if (pos_q == POS_LAST) begin
                            pos_d        = '0;
                            cycle_done_d = 1'b1;
                        end else begin
                            pos_d = pos_q + PW'(1);
                        end
                        leds_d = onehot(pos_d);
                    end
                    M_BOUNCE: begin
                        if (dir_q == DIR_UP) begin
                            if (pos_q == POS_LAST) begin
                                dir_d        = DIR_DOWN;
                                pos_d        = POS_PENULT;
                                // With N=2 the turnaround step lands on 0
                                cycle_done_d = (POS_PENULT == '0);
                            end else begin
                                pos_d = pos_q + PW'(1);
                            end
                        end else begin
                            if (pos_q == '0) begin
                                dir_d = DIR_UP;
                                pos_d = PW'(1);
                            end else begin
                                pos_d        = pos_q - PW'(1);
                                cycle_done_d = (pos_q == PW'(1));
                            end
                        end
                        leds_d = onehot(pos_d);
                    end
                    M_FILL: begin
                        if (empty_q) begin
                            empty_d = 1'b0;
                            pos_d   = '0;
                            leds_d  = N'(1);
                        end else if (pos_q == POS_LAST) begin
                            empty_d      = 1'b1;
                            pos_d        = '0;
                            leds_d       = '0;
                            cycle_done_d = 1'b1;
                        end else begin
                            pos_d  = pos_q + PW'(1);
                            leds_d = therm(pos_d);
                        end
                    end
                    M_TRAIL: begin
                        if (phase_q == PH_FWD) begin
                            if (pos_q == POS_LAST) begin
                                phase_d = PH_BACK;
                                pos_d   = POS_PENULT;
                                leds_d  = upper(pos_d);
                            end else begin
                                pos_d  = pos_q + PW'(1);
                                leds_d = onehot(pos_d);
                            end
                        end else begin
                            if (pos_q == '0) begin
                                phase_d      = PH_FWD;
                                pos_d        = '0;
                                leds_d       = N'(1);
                                cycle_done_d = 1'b1;
                            end else begin
                                pos_d  = pos_q - PW'(1);
                                leds_d = upper(pos_d);
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign leds       = leds_q;
    assign pos        = pos_q;
    assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench: N=4/DIV=3 instance walks every pattern, restart and reset;
// N=2/DIV=1 instance checks the minimal BOUNCE alternation.
module tb_led_pattern_gen;

    logic       clk;
    logic       rst_n_a, en_a;
    logic [1:0] mode_a;
    logic [3:0] leds_a;
    logic [1:0] pos_a;
    logic       cd_a;

    logic       rst_n_b, en_b;
    logic [1:0] mode_b;
    logic [1:0] leds_b;
    logic [0:0] pos_b;
    logic       cd_b;

    int checks   = 0;
    int failures = 0;
    logic [3:0] last_leds;

    led_pattern_gen #(.N(4), .DIV(3)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n_a),
        .en         (en_a),
        .mode       (mode_a),
        .leds       (leds_a),
        .pos        (pos_a),
        .cycle_done (cd_a)
    );

    led_pattern_gen #(.N(2), .DIV(1)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n_b),
        .en         (en_b),
        .mode       (mode_b),
        .leds       (leds_b),
        .pos        (pos_b),
        .cycle_done (cd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One pattern step on dut_a: two held cycles, then the new value
    task automatic step_a(input string tag, input logic [3:0] el, input logic [1:0] ep,
                          input logic ecd);
        tick();
        chk({tag, "_hold_leds"}, 32'(leds_a), 32'(last_leds));
        chk({tag, "_hold_cd"}, 32'(cd_a), 32'(0));
        tick();
        chk({tag, "_hold2_leds"}, 32'(leds_a), 32'(last_leds));
        tick();
        chk({tag, "_leds"}, 32'(leds_a), 32'(el));
        chk({tag, "_pos"}, 32'(pos_a), 32'(ep));
        chk({tag, "_cd"}, 32'(cd_a), 32'(ecd));
        last_leds = el;
    endtask

    // Mode switch on dut_a: restart visible right after the next edge
    task automatic restart_a(input string tag, input logic [1:0] m);
        mode_a = m;
        tick();
        chk({tag, "_leds"}, 32'(leds_a), 32'h1);
        chk({tag, "_pos"}, 32'(pos_a), 32'(0));
        chk({tag, "_cd"}, 32'(cd_a), 32'(0));
        last_leds = 4'b0001;
    endtask

    initial begin
        rst_n_a = 1'b0; en_a = 1'b1; mode_a = 2'd0;
        rst_n_b = 1'b0; en_b = 1'b1; mode_b = 2'd1;
        last_leds = 4'b0001;

        // Reset with en high
        tick();
        tick();
        chk("rst_leds", 32'(leds_a), 32'h1);
        chk("rst_pos", 32'(pos_a), 32'(0));
        chk("rst_cd", 32'(cd_a), 32'(0));
        chk("rst_b_leds", 32'(leds_b), 32'h1);

        // Released but paused: nothing moves
        rst_n_a = 1'b1; en_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("pause_leds", 32'(leds_a), 32'h1);
        end
        chk("pause_cd", 32'(cd_a), 32'(0));

        // SCAN
        en_a = 1'b1;
        step_a("scan1", 4'b0010, 2'd1, 1'b0);
        step_a("scan2", 4'b0100, 2'd2, 1'b0);
        step_a("scan3", 4'b1000, 2'd3, 1'b0);
        step_a("scan4", 4'b0001, 2'd0, 1'b1);
        step_a("scan5", 4'b0010, 2'd1, 1'b0);

        // BOUNCE
        restart_a("to_bounce", 2'd1);
        step_a("bnc1", 4'b0010, 2'd1, 1'b0);
        step_a("bnc2", 4'b0100, 2'd2, 1'b0);
        step_a("bnc3", 4'b1000, 2'd3, 1'b0);
        step_a("bnc4", 4'b0100, 2'd2, 1'b0);
        step_a("bnc5", 4'b0010, 2'd1, 1'b0);
        step_a("bnc6", 4'b0001, 2'd0, 1'b1);
        step_a("bnc7", 4'b0010, 2'd1, 1'b0);

        // FILL
        restart_a("to_fill", 2'd2);
        step_a("fill1", 4'b0011, 2'd1, 1'b0);
        step_a("fill2", 4'b0111, 2'd2, 1'b0);
        step_a("fill3", 4'b1111, 2'd3, 1'b0);
        step_a("fill4", 4'b0000, 2'd0, 1'b1);
        step_a("fill5", 4'b0001, 2'd0, 1'b0);

        // TRAIL
        restart_a("to_trail", 2'd3);
        step_a("trl1", 4'b0010, 2'd1, 1'b0);
        step_a("trl2", 4'b0100, 2'd2, 1'b0);
        step_a("trl3", 4'b1000, 2'd3, 1'b0);
        step_a("trl4", 4'b1100, 2'd2, 1'b0);
        step_a("trl5", 4'b1110, 2'd1, 1'b0);
        step_a("trl6", 4'b1111, 2'd0, 1'b0);
        step_a("trl7", 4'b0001, 2'd0, 1'b1);

        // Mode change while paused mid-SCAN
        restart_a("to_scan", 2'd0);
        step_a("mc1", 4'b0010, 2'd1, 1'b0);
        step_a("mc2", 4'b0100, 2'd2, 1'b0);
        en_a = 1'b0;
        restart_a("mc_restart", 2'd2);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mc_paused_leds", 32'(leds_a), 32'h1);
        end
        en_a = 1'b1;
        step_a("mc_first", 4'b0011, 2'd1, 1'b0);

        // Reset during TRAIL BACK phase
        restart_a("to_trail2", 2'd3);
        step_a("rt1", 4'b0010, 2'd1, 1'b0);
        step_a("rt2", 4'b0100, 2'd2, 1'b0);
        step_a("rt3", 4'b1000, 2'd3, 1'b0);
        step_a("rt4", 4'b1100, 2'd2, 1'b0);
        step_a("rt5", 4'b1110, 2'd1, 1'b0);
        rst_n_a = 1'b0;
        tick();
        chk("midrst_leds", 32'(leds_a), 32'h1);
        chk("midrst_pos", 32'(pos_a), 32'(0));
        chk("midrst_cd", 32'(cd_a), 32'(0));
        rst_n_a = 1'b1;
        last_leds = 4'b0001;
        step_a("post1", 4'b0010, 2'd1, 1'b0);
        step_a("post2", 4'b0100, 2'd2, 1'b0);
        step_a("post3", 4'b1000, 2'd3, 1'b0);
        step_a("post4", 4'b1100, 2'd2, 1'b0);

        // N=2, DIV=1 BOUNCE alternates every cycle
        rst_n_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("n2_leds_hi", 32'(leds_b), 32'h2);
            chk("n2_pos_hi", 32'(pos_b), 32'(1));
            chk("n2_cd_hi", 32'(cd_b), 32'(0));
            tick();
            chk("n2_leds_lo", 32'(leds_b), 32'h1);
            chk("n2_pos_lo", 32'(pos_b), 32'(0));
            chk("n2_cd_lo", 32'(cd_b), 32'(1));
        end
        en_b = 1'b0;
        tick();
        chk("n2_pause_leds", 32'(leds_b), 32'h1);
        chk("n2_pause_cd", 32'(cd_b), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
